hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It works beside the ALU/branch forwarding logic.
- Detects load-use hazards that forwarding cannot cover, and inserts a bubble for them.
- Flushes the front end on a taken branch.
- Runs the multi-cycle RET/RTI and interrupt-entry sequences.
- Drives the stall/flush enables of the PC, F2D and D2E registers, and the PC source select.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/load_use_detect.sv | 14 +
 rtl/hazard_controller.sv | 136 +++++++++++++
 tb/tb_hazard_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and select/push codes for the hazard controller
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RET_WAIT,
        ST_INT_DRAIN,
        ST_INT_PUSH_PC,
        ST_INT_PUSH_FLAGS,
        ST_INT_VECTOR
    } state_t;

    localparam logic [1:0] PCSEL_SEQ    = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_MEM    = 2'd2;
    localparam logic [1:0] PCSEL_VECTOR = 2'd3;

    localparam logic [1:0] PUSH_NONE  = 2'd0;
    localparam logic [1:0] PUSH_PC    = 2'd1;
    localparam logic [1:0] PUSH_FLAGS = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode source that depends on a load still in execute
module load_use_detect (
    input  logic [2:0] src1_d,
    input  logic [2:0] src2_d,
    input  logic [1:0] srcUse_d,
    input  logic [2:0] destAddrAfterD2E,
    input  logic       MTRAfterD2E,
    input  logic       RWAfterD2E,
    output logic       load_use
);
    assign load_use = MTRAfterD2E & RWAfterD2E &
                      ((srcUse_d[0] & (src1_d == destAddrAfterD2E)) |
                       (srcUse_d[1] & (src2_d == destAddrAfterD2E)));
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush, RET wait and interrupt entry sequencing
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] src1_d,
    input  logic [2:0] src2_d,
    input  logic [1:0] srcUse_d,
    input  logic [2:0] destAddrAfterD2E,
    input  logic       MTRAfterD2E,
    input  logic       RWAfterD2E,
    input  logic       branchTaken_e,
    input  logic       isRet_d,
    input  logic       retDone_m,
    input  logic       intr,
    output logic       pcEn,
    output logic       f2dEn,
    output logic       f2dFlush,
    output logic       d2eFlush,
    output logic [1:0] pcSel,
    output logic [1:0] intrPush,
    output logic       intrAck
);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               intrPending;
    logic               load_use;
    logic               pend;
    logic               br;

    load_use_detect u_load_use (
        .src1_d           (src1_d),
        .src2_d           (src2_d),
        .srcUse_d         (srcUse_d),
        .destAddrAfterD2E (destAddrAfterD2E),
        .MTRAfterD2E      (MTRAfterD2E),
        .RWAfterD2E       (RWAfterD2E),
        .load_use         (load_use)
    );

    // A request arriving this very cycle counts, so entry latency is DRAIN_CYCLES+3
    assign pend = intrPending | intr;
    assign br   = branchTaken_e & (state inside {ST_IDLE, ST_RET_WAIT, ST_INT_DRAIN});

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pcEn     = 1'b1;
        f2dEn    = 1'b1;
        f2dFlush = 1'b0;
        d2eFlush = 1'b0;
        pcSel    = PCSEL_SEQ;
        intrPush = PUSH_NONE;
        intrAck  = 1'b0;
        if (rst) begin
            pcEn     = 1'b0;
            f2dFlush = 1'b1;
            d2eFlush = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!branchTaken_e) begin
                        if (load_use) begin
                            pcEn     = 1'b0;
                            f2dEn    = 1'b0;
                            d2eFlush = 1'b1;
                        end else if (pend) begin
                            state_n = ST_INT_DRAIN;
                            cnt_n   = '0;
                        end else if (isRet_d) begin
                            state_n = ST_RET_WAIT;
                        end
                    end
                end
                ST_RET_WAIT: begin
                    pcEn     = retDone_m;
                    f2dFlush = 1'b1;
                    pcSel    = retDone_m ? PCSEL_MEM : PCSEL_SEQ;
                    state_n  = retDone_m ? ST_IDLE : ST_RET_WAIT;
                end
                ST_INT_DRAIN: begin
                    pcEn     = 1'b0;
                    f2dFlush = 1'b1;
                    cnt_n    = cnt + 1'b1;
                    state_n  = (cnt == DRAIN_LAST) ? ST_INT_PUSH_PC : ST_INT_DRAIN;
                end
                ST_INT_PUSH_PC: begin
                    pcEn     = 1'b0;
                    f2dFlush = 1'b1;
                    intrPush = PUSH_PC;
                    state_n  = ST_INT_PUSH_FLAGS;
                end
                ST_INT_PUSH_FLAGS: begin
                    pcEn     = 1'b0;
                    f2dFlush = 1'b1;
                    intrPush = PUSH_FLAGS;
                    state_n  = ST_INT_VECTOR;
                end
                ST_INT_VECTOR: begin
                    f2dFlush = 1'b1;
                    pcSel    = PCSEL_VECTOR;
                    intrAck  = 1'b1;
                    state_n  = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
            // Branch redirect wins over stall/wait outputs; drain keeps counting underneath
            if (br) begin
                pcEn     = 1'b1;
                f2dEn    = 1'b1;
                f2dFlush = 1'b1;
                d2eFlush = 1'b1;
                pcSel    = PCSEL_BRANCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            intrPending <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            intrPending <= (state == ST_INT_VECTOR) ? 1'b0 : (intrPending | intr);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench, expected output vectors queued per driven cycle
module tb_hazard_controller;

    // {pcEn, f2dEn, f2dFlush, d2eFlush, pcSel, intrPush, intrAck}
    localparam logic [8:0] DEF   = 9'b1100_00_00_0;
    localparam logic [8:0] RST   = 9'b0111_00_00_0;
    localparam logic [8:0] STALL = 9'b0001_00_00_0;
    localparam logic [8:0] BR    = 9'b1111_01_00_0;
    localparam logic [8:0] WT    = 9'b0110_00_00_0;
    localparam logic [8:0] RD    = 9'b1110_10_00_0;
    localparam logic [8:0] PPC   = 9'b0110_00_01_0;
    localparam logic [8:0] PFL   = 9'b0110_00_10_0;
    localparam logic [8:0] VEC   = 9'b1110_11_00_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] src1_d, src2_d, destAddrAfterD2E;
    logic [1:0] srcUse_d;
    logic       MTRAfterD2E, RWAfterD2E, branchTaken_e, isRet_d, retDone_m, intr;
    logic       pcEn, f2dEn, f2dFlush, d2eFlush, intrAck;
    logic [1:0] pcSel, intrPush;
    logic [8:0] obs;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int errors = 0;
    int checks = 0;

    hazard_controller #(.DRAIN_CYCLES(3), .CNT_W(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .src1_d           (src1_d),
        .src2_d           (src2_d),
        .srcUse_d         (srcUse_d),
        .destAddrAfterD2E (destAddrAfterD2E),
        .MTRAfterD2E      (MTRAfterD2E),
        .RWAfterD2E       (RWAfterD2E),
        .branchTaken_e    (branchTaken_e),
        .isRet_d          (isRet_d),
        .retDone_m        (retDone_m),
        .intr             (intr),
        .pcEn             (pcEn),
        .f2dEn            (f2dEn),
        .f2dFlush         (f2dFlush),
        .d2eFlush         (d2eFlush),
        .pcSel            (pcSel),
        .intrPush         (intrPush),
        .intrAck          (intrAck)
    );

    always #5 clk = ~clk;

    assign obs = {pcEn, f2dEn, f2dFlush, d2eFlush, pcSel, intrPush, intrAck};

    task automatic clr();
        src1_d = 0; src2_d = 0; srcUse_d = 0; destAddrAfterD2E = 0;
        MTRAfterD2E = 0; RWAfterD2E = 0; branchTaken_e = 0;
        isRet_d = 0; retDone_m = 0; intr = 0;
    endtask

    task automatic tick(input logic [8:0] e);
        exp_q.push_back(e);
        @(negedge clk);
        obs_q.push_back(obs);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        int n = 0;
        rst = 1; tick(RST); tick(RST);
        rst = 0; tick(DEF); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL reset step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_load_use();
        logic [8:0] e, o;
        int n = 0;
        clr();
        MTRAfterD2E = 1; RWAfterD2E = 1; destAddrAfterD2E = 3; src2_d = 3; srcUse_d = 2'b10;
        tick(STALL);
        MTRAfterD2E = 0; tick(DEF);
        src1_d = 5; destAddrAfterD2E = 5; src2_d = 0; srcUse_d = 2'b01; MTRAfterD2E = 1;
        tick(STALL);
        RWAfterD2E = 0; tick(DEF);
        clr(); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL load_use step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_no_match();
        logic [8:0] e, o;
        int n = 0;
        clr();
        MTRAfterD2E = 1; RWAfterD2E = 1; destAddrAfterD2E = 3; src2_d = 3; srcUse_d = 2'b01; src1_d = 4;
        tick(DEF);
        srcUse_d = 2'b00; src1_d = 3; tick(DEF);
        clr();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL no_match step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_branch_priority();
        logic [8:0] e, o;
        int n = 0;
        clr();
        MTRAfterD2E = 1; RWAfterD2E = 1; destAddrAfterD2E = 3; src2_d = 3; srcUse_d = 2'b10; branchTaken_e = 1;
        tick(BR);
        clr(); branchTaken_e = 1; isRet_d = 1; tick(BR);
        clr(); tick(DEF); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL branch_priority step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_ret();
        logic [8:0] e, o;
        int n = 0;
        clr();
        isRet_d = 1; tick(DEF);
        isRet_d = 0; repeat (4) tick(WT);
        retDone_m = 1; tick(RD);
        retDone_m = 0; tick(DEF); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL ret step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_interrupt();
        logic [8:0] e, o;
        int n = 0;
        clr();
        intr = 1; tick(DEF);
        intr = 0; repeat (3) tick(WT);
        tick(PPC); tick(PFL); tick(VEC); tick(DEF); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL interrupt step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_drain_branch();
        logic [8:0] e, o;
        int n = 0;
        clr();
        intr = 1; tick(DEF);
        intr = 0; tick(WT);
        branchTaken_e = 1; tick(BR);
        branchTaken_e = 0; tick(WT);
        tick(PPC); tick(PFL); tick(VEC); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL drain_branch step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_level_intr();
        logic [8:0] e, o;
        int n = 0;
        clr();
        intr = 1; tick(DEF);
        repeat (3) tick(WT);
        tick(PPC); tick(PFL); tick(VEC);
        tick(DEF);
        intr = 0; tick(WT);
        rst = 1; tick(RST);
        rst = 0; tick(DEF); tick(DEF); tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL level_intr step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    task automatic test_intr_ret_rst();
        logic [8:0] e, o;
        int n = 0;
        clr();
        isRet_d = 1; tick(DEF);
        isRet_d = 0; intr = 1; tick(WT);
        intr = 0; tick(WT); tick(WT);
        retDone_m = 1; tick(RD);
        retDone_m = 0; tick(DEF);
        repeat (3) tick(WT);
        rst = 1; tick(RST);
        rst = 0; repeat (8) tick(DEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
            if (o !== e) begin errors++; $display("FAIL intr_ret_rst step %0d: observed %b expected %b", n, o, e); end
        end
    endtask

    initial begin
        clr();
        rst = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_match();
        test_branch_priority();
        test_ret();
        test_interrupt();
        test_drain_branch();
        test_level_intr();
        test_intr_ret_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
